pll_reconfig_seq: RTL and testbench
===================================

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1048576, the maximum number of cycles to wait for lock after the start write.
REQ-002 SHALL have parameter SETTLE, default 16, the number of cycles to ignore locked after the start write.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_req  in  1  a single-cycle request to reprogram the PLL.
REQ-006 SHALL have port cfg_sel  in  1  profile select: 0 = NTSC 85.909080 MHz profile, 1 = PAL profile.
REQ-007 SHALL have port pll_locked  in  1  the PLL locked output.
REQ-008 SHALL have port mgmt_address  out  6  the reconfig-controller register address.
REQ-009 SHALL have port mgmt_write  out  1  the Avalon-MM write strobe.
REQ-010 SHALL have port mgmt_writedata  out  32  the write data.
REQ-011 SHALL have port mgmt_waitrequest  in  1  controller stall; a write is accepted when mgmt_write=1 and mgmt_waitrequest=0.
REQ-012 SHALL have port cfg_busy  out  1  high from request acceptance until the DONE or ERR state is reached.
REQ-013 SHALL have port cfg_done  out  1  a one-cycle pulse on successful relock.
REQ-014 SHALL have port cfg_err  out  1  lock timeout; sticky until the next accepted request.
REQ-015 SHALL have port active_sel  out  1  the profile most recently programmed successfully.

Function
REQ-016 States SHALL be IDLE, WRITE, SETTLE, WAIT_LOCK, DONE and ERR; DONE and ERR SHALL each last one cycle and then return to IDLE.
REQ-017 In IDLE, cfg_req=1 SHALL latch cfg_sel, clear cfg_err, reset the step index to 0 and enter WRITE on the next edge.
REQ-018 cfg_req SHALL be ignored in every state other than IDLE.
REQ-019 WRITE SHALL issue 8 writes in order:
- 0: addr 0, data 0 (waitrequest mode)
- 1: addr 4, M counter
- 2: addr 7, K fractional value
- 3..6: addr 5, C0..C3 counters
- 7: addr 2, data 1 (start)
REQ-020 mgmt_address, mgmt_writedata and mgmt_write SHALL be held stable while mgmt_waitrequest=1.
REQ-021 After an accepted write the step index SHALL advance; with zero wait states there SHALL be one write per cycle, so 8 writes take 8 cycles.
REQ-022 Acceptance of step 7 SHALL drop mgmt_write on the next edge and enter SETTLE.
REQ-023 SETTLE SHALL count SETTLE cycles, ignoring pll_locked, then enter WAIT_LOCK.
REQ-024 In WAIT_LOCK, pll_locked=1 SHALL enter DONE, update active_sel to the latched select, and pulse cfg_done in the DONE cycle.
REQ-025 If LOCK_TIMEOUT cycles elapse in WAIT_LOCK without lock, the block SHALL enter ERR and set cfg_err; active_sel SHALL be left unchanged.
REQ-026 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-027 The timeout counter SHALL be sized clog2(LOCK_TIMEOUT+1) and SHALL saturate, never wrap.
REQ-028 C counter word format: [22:18] counter index, [17] odd-duty enable, [16] bypass, [15:8] high count, [7:0] low count.
REQ-029 M and N word format: [17] odd-duty enable, [16] bypass, [15:8] high count, [7:0] low count.

Reset
REQ-030 On rst_n=0 at a clock edge, the block SHALL force IDLE and drive mgmt_write=0, mgmt_address=0, mgmt_writedata=0, cfg_busy=0, cfg_done=0, cfg_err=0, active_sel=0.
REQ-031 A reset during WRITE SHALL deassert mgmt_write at that same edge, regardless of mgmt_waitrequest.

Structure
REQ-032 Package pll_reconfig_pkg SHALL hold the register address constants, the word-format field positions, and a profile type {m, k, c[0:3]}.
REQ-033 Package pll_reconfig_pkg SHALL hold the NTSC profile: M 0x00000404, K 2537930535, C0 0x00020302, C1 0x00060302, C2 0x00080505, C3 0x000C0A0A.
REQ-034 Package pll_reconfig_pkg SHALL hold the PAL profile constants.
REQ-035 One sub-module, pll_profile_rom, SHALL be used: a combinational lookup of (sel, step) to (address, data).

Verification
REQ-036 Zero waitrequest, cfg_sel=0, pulse cfg_req -> 8 consecutive writes (addr 0,4,7,5,5,5,5,2); data matches REQ-019 and REQ-033; cfg_busy=1 from the following cycle.
REQ-037 mgmt_waitrequest=1 for 3 cycles at step 2 -> addr 7 and data 2537930535 held for 4 cycles; exactly one acceptance; total sequence length 11 cycles.
REQ-038 SETTLE=16, pll_locked raised 5 cycles after SETTLE ends -> cfg_done pulses once; active_sel=0; cfg_busy falls.
REQ-039 LOCK_TIMEOUT=100, pll_locked held 0 -> ERR after 100 WAIT_LOCK cycles; cfg_err=1 stays set; next cfg_req clears it.
REQ-040 cfg_req during WRITE step 4 -> ignored; exactly 8 writes total; cfg_sel changes mid-sequence do not alter the data.
REQ-041 rst_n=0 while mgmt_write=1 and mgmt_waitrequest=1 -> all outputs 0 at that edge; a subsequent cfg_req restarts the sequence at step 0.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration sequencer: controller register map,
// counter word layout, sequencer states and the two video-clock profiles.
package pll_reconfig_pkg;

  localparam int unsigned NUM_STEPS = 8;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;

  localparam logic [31:0] MODE_WAITREQ = 32'd0;
  localparam logic [31:0] START_GO     = 32'd1;

  localparam int unsigned CNT_IDX_LSB    = 18;
  localparam int unsigned CNT_IDX_W      = 5;
  localparam int unsigned CNT_ODD_BIT    = 17;
  localparam int unsigned CNT_BYPASS_BIT = 16;
  localparam int unsigned CNT_HI_LSB     = 8;
  localparam int unsigned CNT_LO_LSB     = 0;
  localparam int unsigned CNT_HALF_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } seq_state_t;

  typedef struct packed {
    logic [31:0]           m;
    logic [31:0]           k;
    logic [0:3][31:0]      c;
  } pll_profile_t;

  // M/N words share the C layout with the counter-index field left at zero.
  function automatic logic [31:0] cnt_word(logic [4:0] idx, logic odd, logic bypass,
                                           logic [7:0] hi, logic [7:0] lo);
    logic [31:0] w;
    w = '0;
    w[CNT_IDX_LSB +: CNT_IDX_W]  = idx;
    w[CNT_ODD_BIT]               = odd;
    w[CNT_BYPASS_BIT]            = bypass;
    w[CNT_HI_LSB +: CNT_HALF_W]  = hi;
    w[CNT_LO_LSB +: CNT_HALF_W]  = lo;
    return w;
  endfunction

  localparam pll_profile_t PROFILE_NTSC = '{
    m: 32'h0000_0404,
    k: 32'd2537930535,
    c: {32'h0002_0302, 32'h0006_0302, 32'h0008_0505, 32'h000C_0A0A}
  };

  localparam pll_profile_t PROFILE_PAL = '{
    m: cnt_word(5'd0, 1'b0, 1'b0, 8'd5, 8'd5),
    k: 32'd1288490189,
    c: {cnt_word(5'd0, 1'b0, 1'b0, 8'd4, 8'd4),
        cnt_word(5'd1, 1'b0, 1'b0, 8'd4, 8'd4),
        cnt_word(5'd2, 1'b1, 1'b0, 8'd6, 8'd5),
        cnt_word(5'd3, 1'b0, 1'b0, 8'd12, 8'd12)}
  };

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM write-only link from the sequencer to the PLL reconfiguration controller.
interface pll_reconfig_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_profile_rom.sv
// Combinational lookup of the register write issued at each step of a profile load.
module pll_profile_rom
  import pll_reconfig_pkg::*;
(
  input  logic        sel,
  input  logic [2:0]  step,
  output logic [5:0]  address,
  output logic [31:0] data
);

  pll_profile_t prof;

  always_comb begin
    prof    = sel ? PROFILE_PAL : PROFILE_NTSC;
    address = ADDR_MODE;
    data    = MODE_WAITREQ;
    case (step)
      3'd0: begin address = ADDR_MODE;  data = MODE_WAITREQ; end
      3'd1: begin address = ADDR_M;     data = prof.m;       end
      3'd2: begin address = ADDR_K;     data = prof.k;       end
      3'd3: begin address = ADDR_C;     data = prof.c[0];    end
      3'd4: begin address = ADDR_C;     data = prof.c[1];    end
      3'd5: begin address = ADDR_C;     data = prof.c[2];    end
      3'd6: begin address = ADDR_C;     data = prof.c[3];    end
      default: begin address = ADDR_START; data = START_GO;  end
    endcase
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Reprograms the PLL to the selected video profile, then waits (bounded) for relock.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned SETTLE       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_req,
  input  logic                      cfg_sel,
  input  logic                      pll_locked,
  pll_reconfig_seq_if.master        mgmt,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic                      active_sel
);

  localparam int unsigned TO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned ST_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(LOCK_TIMEOUT);
  localparam logic [2:0]      LAST_STEP = 3'(NUM_STEPS - 1);

  seq_state_t      state, state_next;
  logic [2:0]      step;
  logic            sel_q;
  logic [ST_W-1:0] settle_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            settle_last;
  logic            timeout_last;
  logic [5:0]      rom_address;
  logic [31:0]     rom_data;

  pll_profile_rom u_rom (
    .sel     (sel_q),
    .step    (step),
    .address (rom_address),
    .data    (rom_data)
  );

  assign settle_last  = (32'(settle_cnt) + 32'd1) >= SETTLE;
  assign timeout_last = (32'(to_cnt) + 32'd1) >= LOCK_TIMEOUT;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Bus outputs are decoded from state so a reset edge drops mgmt_write even mid-stall.
  always_comb begin
    state_next          = state;
    accept              = 1'b0;
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_address   = '0;
    mgmt.mgmt_writedata = '0;
    cfg_busy            = 1'b0;
    cfg_done            = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_req) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = rom_address;
        mgmt.mgmt_writedata = rom_data;
        cfg_busy            = 1'b1;
        accept              = !mgmt.mgmt_waitrequest;
        if (accept && step == LAST_STEP)
          state_next = (SETTLE == 0) ? ST_WAIT_LOCK : ST_SETTLE;
      end
      ST_SETTLE: begin
        cfg_busy = 1'b1;
        if (settle_last) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cfg_busy = 1'b1;
        if (pll_locked)        state_next = ST_DONE;
        else if (timeout_last) state_next = ST_ERR;
      end
      ST_DONE: begin
        cfg_done   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step       <= '0;
      sel_q      <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      cfg_err    <= 1'b0;
      active_sel <= 1'b0;
    end else begin
      if (state == ST_IDLE && cfg_req) begin
        sel_q   <= cfg_sel;
        step    <= '0;
        cfg_err <= 1'b0;
      end else if (accept) begin
        step <= step + 3'd1;
      end

      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;

      if (state != ST_WAIT_LOCK)  to_cnt <= '0;
      else if (to_cnt != TO_MAX)  to_cnt <= to_cnt + 1'b1;

      if (state_next == ST_DONE) active_sel <= sel_q;
      if (state_next == ST_ERR)  cfg_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed-plus-random bench for pll_reconfig_seq against a table-driven reference of the write sequence.
module tb_pll_reconfig_seq;

  localparam int TB_TIMEOUT = 100;
  localparam int TB_SETTLE  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_req = 1'b0;
  logic cfg_sel = 1'b0;
  logic pll_locked = 1'b0;
  logic cfg_busy, cfg_done, cfg_err, active_sel;

  pll_reconfig_seq_if mgmt ();

  int n_vec = 0;
  int n_bad = 0;

  logic        m_active = 1'b0;
  logic        m_err    = 1'b0;
  logic [5:0]  ref_addr [8];
  logic [31:0] ref_data [2][8];

  pll_reconfig_seq #(
    .LOCK_TIMEOUT (TB_TIMEOUT),
    .SETTLE       (TB_SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_sel    (cfg_sel),
    .pll_locked (pll_locked),
    .mgmt       (mgmt.master),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .active_sel (active_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_busy", 32'(cfg_busy), 32'd0);
      check("idle_done", 32'(cfg_done), 32'd0);
      check("idle_write", 32'(mgmt.mgmt_write), 32'd0);
      check("idle_err", 32'(cfg_err), 32'(m_err));
      check("idle_active", 32'(active_sel), 32'(m_active));
      @(negedge clk);
    end
  endtask

  // Request a load, then walk the 8 expected writes, stalling stall_len cycles at stall_step
  // and optionally pulsing a (to be ignored) request at req_step.
  task automatic run_writes(input logic sel, input int stall_step, input int stall_len,
                            input int req_step);
    int s, left, cyc;
    logic stall;
    cfg_req = 1'b1;
    cfg_sel = sel;
    mgmt.mgmt_waitrequest = 1'($urandom_range(1, 0));
    @(negedge clk);
    cfg_req = 1'b0;
    m_err = 1'b0;
    check("busy_after_req", 32'(cfg_busy), 32'd1);
    check("err_cleared", 32'(cfg_err), 32'd0);
    s = 0; left = stall_len; cyc = 0;
    while (s < 8 && cyc < 40) begin
      check($sformatf("write_s%0d", s), 32'(mgmt.mgmt_write), 32'd1);
      check($sformatf("addr_s%0d", s), 32'(mgmt.mgmt_address), 32'(ref_addr[s]));
      check($sformatf("data_s%0d", s), mgmt.mgmt_writedata, ref_data[sel][s]);
      stall = (s == stall_step) && (left > 0);
      if (stall) left--;
      mgmt.mgmt_waitrequest = stall;
      cfg_req = (s == req_step) && !stall;
      cfg_sel = 1'($urandom_range(1, 0));
      @(negedge clk);
      cyc++;
      cfg_req = 1'b0;
      if (!stall) s++;
    end
    mgmt.mgmt_waitrequest = 1'b0;
    check("write_cycles", 32'(cyc), 32'(8 + stall_len));
    check("write_dropped", 32'(mgmt.mgmt_write), 32'd0);
  endtask

  // Settle window with random lock noise, then a one-cycle lock at WAIT_LOCK cycle lock_at
  // (negative or >= timeout means the PLL never locks).
  task automatic finish_seq(input logic sel, input int lock_at);
    logic ok;
    for (int i = 0; i < TB_SETTLE; i++) begin
      check("settle_busy", 32'(cfg_busy), 32'd1);
      check("settle_done", 32'(cfg_done), 32'd0);
      check("settle_write", 32'(mgmt.mgmt_write), 32'd0);
      pll_locked = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    pll_locked = 1'b0;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      check("wait_busy", 32'(cfg_busy), 32'd1);
      check("wait_done", 32'(cfg_done), 32'd0);
      pll_locked = (k == lock_at);
      @(negedge clk);
      if (k == lock_at) break;
    end
    pll_locked = 1'b0;
    ok = (lock_at >= 0) && (lock_at < TB_TIMEOUT);
    if (ok) m_active = sel;
    else    m_err = 1'b1;
    check("end_done", 32'(cfg_done), 32'(ok));
    check("end_err", 32'(cfg_err), 32'(m_err));
    check("end_busy", 32'(cfg_busy), 32'd0);
    check("end_active", 32'(active_sel), 32'(m_active));
    @(negedge clk);
    check("post_done", 32'(cfg_done), 32'd0);
    check("post_err", 32'(cfg_err), 32'(m_err));
    check("post_active", 32'(active_sel), 32'(m_active));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write"}, 32'(mgmt.mgmt_write), 32'd0);
    check({tag, "_addr"}, 32'(mgmt.mgmt_address), 32'd0);
    check({tag, "_data"}, mgmt.mgmt_writedata, 32'd0);
    check({tag, "_busy"}, 32'(cfg_busy), 32'd0);
    check({tag, "_done"}, 32'(cfg_done), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_active"}, 32'(active_sel), 32'd0);
  endtask

  initial begin
    ref_addr    = '{6'd0, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd5, 6'd2};
    ref_data[0] = '{32'd0, 32'h0000_0404, 32'd2537930535, 32'h0002_0302,
                    32'h0006_0302, 32'h0008_0505, 32'h000C_0A0A, 32'd1};
    ref_data[1] = '{32'd0, 32'h0000_0505, 32'd1288490189, 32'h0000_0404,
                    32'h0004_0404, 32'h000A_0605, 32'h000C_0C0C, 32'd1};
    mgmt.mgmt_waitrequest = 1'b0;

    // Reset with a request held: nothing may start.
    rst_n = 1'b0;
    cfg_req = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    cfg_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    idle_cycles(2);

    // NTSC, zero wait states, stray request mid-sequence, lock 5 cycles after settle.
    run_writes(1'b0, 99, 0, 4);
    finish_seq(1'b0, 5);
    idle_cycles(2);

    // Three-cycle stall on the K write.
    run_writes(1'b0, 2, 3, -1);
    finish_seq(1'b0, int'($urandom_range(20, 0)));
    idle_cycles(1);

    // PAL, lock arrives in the same cycle the timeout would fire.
    run_writes(1'b1, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), int'($urandom_range(7, 0)));
    finish_seq(1'b1, TB_TIMEOUT - 1);
    idle_cycles(1);

    // NTSC, no lock: timeout must leave active_sel at PAL and keep cfg_err sticky.
    run_writes(1'b0, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), -1);
    finish_seq(1'b0, -1);
    idle_cycles(5);

    // Reset while stalled on a write: everything clears at that edge.
    cfg_req = 1'b1;
    cfg_sel = 1'b1;
    mgmt.mgmt_waitrequest = 1'b0;
    @(negedge clk);
    cfg_req = 1'b0;
    m_err = 1'b0;
    check("rst_seq_err_cleared", 32'(cfg_err), 32'd0);
    repeat (2) @(negedge clk);
    mgmt.mgmt_waitrequest = 1'b1;
    check("rst_seq_write", 32'(mgmt.mgmt_write), 32'd1);
    check("rst_seq_addr", 32'(mgmt.mgmt_address), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_active = 1'b0;
    check_all_zero("midrst");
    rst_n = 1'b1;
    mgmt.mgmt_waitrequest = 1'b0;
    @(negedge clk);
    idle_cycles(1);

    // Restart from step 0 after reset, then a few fully random loads.
    run_writes(1'b0, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), -1);
    finish_seq(1'b0, int'($urandom_range(30, 0)));
    for (int r = 0; r < 3; r++) begin
      logic sel;
      sel = 1'($urandom_range(1, 0));
      idle_cycles(int'($urandom_range(3, 1)));
      run_writes(sel, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(9, 0)));
      finish_seq(sel, int'($urandom_range(30, 0)));
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
